// File: rtl/fp_pkg.sv
// Shared binary32 constants, FSM state and operand class encodings for the FP datapath blocks.
package fp_pkg;
  localparam int BIAS   = 127;
  localparam int EXP_W  = 8;
  localparam int FRAC_W = 23;

  localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_ROUND,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    FP_ZERO,
    FP_DENORM,
    FP_NORMAL,
    FP_INF,
    FP_NAN
  } fp_class_t;
endpackage

// File: rtl/fp_unpack.sv
// Combinational binary32 field split: sign, significand with hidden bit, unbiased exponent, class.
module fp_unpack
  import fp_pkg::*;
(
  input  logic              i_a,
  input  logic [30:0]       i_mag_bits,
  output logic              o_sign,
  output logic [FRAC_W:0]   o_mant,
  output logic signed [9:0] o_e,
  output logic [2:0]        o_class
);
  logic [EXP_W-1:0]  w_exp;
  logic [FRAC_W-1:0] w_frac;
  logic              w_hidden;
  fp_class_t         w_cls;

  assign w_exp    = i_mag_bits[30:23];
  assign w_frac   = i_mag_bits[22:0];
  assign w_hidden = (w_exp != '0);
  assign o_sign   = i_a;
  assign o_mant   = {w_hidden, w_frac};
  assign o_e      = $signed({2'b00, w_exp}) - 10'(BIAS);

  always_comb begin
    w_cls = FP_NORMAL;
    if (w_exp == '1)
      w_cls = (w_frac != '0) ? FP_NAN : FP_INF;
    else if (w_exp == '0)
      w_cls = (w_frac != '0) ? FP_DENORM : FP_ZERO;
  end

  assign o_class = w_cls;
endmodule

// File: rtl/fp_to_int.sv
// binary32 -> int32 converter, round-to-nearest-even, one significand bit shifted per cycle.
// state | meaning: IDLE accept operand | SHIFT align significand | ROUND apply RNE, sign | DONE hold result
module fp_to_int
  import fp_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] res,
  output logic        ovf,
  output logic        inexact
);
  localparam logic [31:0] NEG_2P31 = 32'hCF00_0000;

  state_t      r_state;
  logic [4:0]  r_count;
  logic [31:0] r_mag;
  logic        r_sign;
  logic        r_dir_right;
  logic        r_guard;
  logic        r_sticky;
  logic [31:0] r_res;
  logic        r_ovf;
  logic        r_inexact;
  logic        r_out_valid;

  logic              w_sign;
  logic [FRAC_W:0]   w_mant;
  logic signed [9:0] w_e;
  logic [2:0]        w_class;
  logic              w_right;
  logic [4:0]        w_cnt;
  logic              w_inc;
  logic [31:0]       w_mag_rnd;

  fp_unpack u_unpack (
    .i_a        (a[31]),
    .i_mag_bits (a[30:0]),
    .o_sign     (w_sign),
    .o_mant     (w_mant),
    .o_e        (w_e),
    .o_class    (w_class)
  );

  // Only -1 <= E <= 30 reaches this count, so 5-bit modular arithmetic is exact.
  assign w_right   = (w_e < 10'sd23);
  assign w_cnt     = w_right ? (5'd23 - w_e[4:0]) : (w_e[4:0] - 5'd23);
  assign w_inc     = r_guard & (r_sticky | r_mag[0]);
  assign w_mag_rnd = r_mag + {31'b0, w_inc};

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign res       = r_res;
  assign ovf       = r_ovf;
  assign inexact   = r_inexact;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_count     <= '0;
      r_mag       <= '0;
      r_sign      <= 1'b0;
      r_dir_right <= 1'b0;
      r_guard     <= 1'b0;
      r_sticky    <= 1'b0;
      r_res       <= '0;
      r_ovf       <= 1'b0;
      r_inexact   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_sign      <= w_sign;
          r_guard     <= 1'b0;
          r_sticky    <= 1'b0;
          r_ovf       <= 1'b0;
          r_inexact   <= 1'b0;
          r_mag       <= {8'b0, w_mant};
          r_dir_right <= w_right;
          r_count     <= '0;
          if (a == NEG_2P31) begin
            r_res       <= INT_MIN;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (w_class == FP_NAN) begin
            r_res       <= INT_MAX;
            r_ovf       <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (w_class == FP_INF || w_e >= 10'sd31) begin
            r_res       <= w_sign ? INT_MIN : INT_MAX;
            r_ovf       <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else if (w_e <= -10'sd2) begin
            r_res       <= '0;
            r_inexact   <= (w_class != FP_ZERO);
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_count <= w_cnt;
            r_state <= (w_cnt == 5'd0) ? S_ROUND : S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (r_dir_right) begin
            r_mag    <= r_mag >> 1;
            r_guard  <= r_mag[0];
            r_sticky <= r_sticky | r_guard;
          end else begin
            r_mag <= r_mag << 1;
          end
          r_count <= r_count - 5'd1;
          if (r_count == 5'd1) r_state <= S_ROUND;
        end
        S_ROUND: begin
          r_res       <= r_sign ? -w_mag_rnd : w_mag_rnd;
          r_inexact   <= r_guard | r_sticky;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: if (out_ready) begin
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_fp_to_int.sv
// Scoreboard bench for fp_to_int: directed corner operands, backpressure, mid-op reset, random operands.
module tb_fp_to_int;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic        ovf;
  logic        inexact;

  typedef struct {
    logic [31:0] op;
    logic [31:0] res;
    logic        ovf;
    logic        inexact;
    int          lat;
    int          k;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ready_mode = 0;
  bit   seen_rise = 0;
  bit   just_popped = 0;

  fp_to_int dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .ovf       (ovf),
    .inexact   (inexact)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 2) != 0);
        default: out_ready = 1'b0;
      endcase
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: value = M * 2^(E-23), rounded by comparing the dropped remainder against one half.
  function automatic exp_t model(input logic [31:0] v);
    exp_t   x;
    int     e;
    int     sh;
    longint m, q, rem, half;
    logic [7:0]  ex;
    logic [22:0] fr;
    ex = v[30:23];
    fr = v[22:0];
    x.op = v; x.ovf = 1'b0; x.inexact = 1'b0; x.lat = 1; x.k = 0; x.res = 32'h0;
    e = int'(ex) - 127;
    m = (ex != 0) ? (longint'(fr) + 64'd8388608) : longint'(fr);
    if (v == 32'hCF000000) begin
      x.res = 32'h80000000;
    end else if (ex == 8'hFF && fr != 0) begin
      x.res = 32'h7FFFFFFF; x.ovf = 1'b1;
    end else if (ex == 8'hFF || e >= 31) begin
      x.res = v[31] ? 32'h80000000 : 32'h7FFFFFFF; x.ovf = 1'b1;
    end else if (e <= -2) begin
      x.inexact = (v[30:0] != 0);
    end else begin
      if (e >= 23) begin
        q = m << (e - 23);
        x.lat = e - 23 + 2;
      end else begin
        sh = 23 - e;
        q = m >> sh;
        rem = m - (q << sh);
        half = 64'd1 << (sh - 1);
        if (rem > half || (rem == half && q[0])) q = q + 1;
        x.inexact = (rem != 0);
        x.lat = sh + 2;
      end
      x.res = v[31] ? 32'(-q) : 32'(q);
    end
    return x;
  endfunction

  task automatic send(input logic [31:0] v);
    int   n;
    exp_t x;
    n = 0;
    @(negedge clk);
    a = v;
    in_valid = 1'b1;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL accept_timeout: in_ready stayed %b, expected 1", in_ready);
    end else begin
      x = model(v);
      x.k = cyc;
      sb.push_back(x);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial forever begin
    exp_t cur;
    @(negedge clk);
    if (!rst) begin
      if (just_popped) begin
        chk("single_xfer", {31'b0, out_valid}, 32'h0);
        just_popped = 0;
      end else if (out_valid) begin
        if (sb.size() == 0) begin
          chk("unexpected_valid", {31'b0, out_valid}, 32'h0);
        end else begin
          cur = sb[0];
          if (!seen_rise) begin
            seen_rise = 1;
            chk($sformatf("latency[%h]", cur.op), 32'(cyc - cur.k), 32'(cur.lat));
          end
          chk($sformatf("res[%h]", cur.op), res, cur.res);
          chk($sformatf("ovf[%h]", cur.op), {31'b0, ovf}, {31'b0, cur.ovf});
          chk($sformatf("inexact[%h]", cur.op), {31'b0, inexact}, {31'b0, cur.inexact});
          chk("in_ready_in_done", {31'b0, in_ready}, 32'h0);
          if (out_ready) begin
            void'(sb.pop_front());
            seen_rise = 0;
            just_popped = 1;
          end
        end
      end
    end
  end

  logic [31:0] directed [16] = '{
    32'h40490FDB, 32'h3FC00000, 32'h40200000, 32'hBFC00000,
    32'hCF000000, 32'h4F000000, 32'h7FC00000, 32'h4B000000,
    32'h00000001, 32'h80000000, 32'h7F800000, 32'hFF800000,
    32'h3F000000, 32'h3F400000, 32'h4EFFFFFF, 32'hCEFFFFFF
  };

  initial begin
    logic [31:0] r;
    logic [7:0]  ex;
    int          sel;
    int          n;
    rst = 1'b1;
    in_valid = 1'b0;
    a = 32'h0;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_res", res, 32'h0);
    chk("rst_ovf", {31'b0, ovf}, 32'h0);
    chk("rst_inexact", {31'b0, inexact}, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;

    foreach (directed[i]) send(directed[i]);
    drain();

    // Output held under backpressure, then exactly one transfer.
    ready_mode = 2;
    send(32'h4B000000);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    ready_mode = 0;
    drain();

    // Reset in the middle of a long right shift.
    send(32'h3F800000);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("midrst_res", res, 32'h0);
    chk("midrst_ovf", {31'b0, ovf}, 32'h0);
    chk("midrst_inexact", {31'b0, inexact}, 32'h0);
    chk("midrst_in_ready", {31'b0, in_ready}, 32'h1);
    sb.delete();
    seen_rise = 0;
    just_popped = 0;
    @(negedge clk);
    #2 rst = 1'b0;
    repeat (30) @(negedge clk);
    send(32'h3F800000);
    drain();

    ready_mode = 1;
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 9);
      r = $urandom;
      case (sel)
        0: ex = r[30:23];
        1: ex = 8'h00;
        2: ex = 8'hFF;
        default: ex = 8'($urandom_range(124, 159));
      endcase
      if (sel == 3) r = r & 32'hFFF0_0000;
      send({r[31], ex, r[22:0]});
    end
    drain();
    ready_mode = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_to_int.md
FP_TO_INT -- requirements
Module: fp_to_int

Interface
REQ-001 The module SHALL use one clock and an asynchronous, active-high reset, as listed below.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_valid  input  1  operand a is presented
- in_ready  output  1  block can accept; high exactly in state IDLE
- a  input  32  IEEE-754 binary32 operand (sign a[31], exp a[30:23], frac a[22:0])
- out_valid  output  1  res and flags valid, held until accepted
- out_ready  input  1  consumer accepts res
- res  output  32  signed two's-complement int32 result
- ovf  output  1  invalid/overflow: NaN, Inf or out-of-range, result saturated
- inexact  output  1  discarded fraction was nonzero

Function
REQ-002 Transfers SHALL occur only on clock edges where valid and ready are both high; a is sampled on the input-transfer edge.
REQ-003 Rounding SHALL be round-to-nearest-even, matching the team FP adder.
REQ-004 Decode at accept: E = exp - 127; M = {hidden, frac}; hidden = 0 when exp == 0, else 1.
REQ-005 Classes decided at accept, next state DONE directly:
- exp == 255 with frac != 0 (NaN): res = 0x7FFFFFFF, ovf = 1.
- exp == 255 with frac == 0 (Inf), or E >= 31: res = 0x7FFFFFFF (sign 0) or 0x80000000 (sign 1), ovf = 1.
- Exception to the above: a == 0xCF000000: res = 0x80000000, ovf = 0, inexact = 0.
- E <= -2 (includes zeros and denormals): res = 0, inexact = (exp != 0 or frac != 0).
REQ-006 All other inputs (-1 <= E <= 30) SHALL go to SHIFT with count = |E - 23|, direction right if E < 23, left otherwise; count == 0 SHALL go straight to ROUND.
REQ-007 SHIFT SHALL move M exactly one bit per cycle and decrement count, exiting to ROUND on the cycle count reaches 0.
REQ-008 On right shifts:
- guard = last bit shifted out.
- sticky = OR of all earlier shifted-out bits.
- Both are cleared at accept.
REQ-009 ROUND (one cycle):
- Increment magnitude when guard & (sticky | lsb).
- inexact = guard | sticky.
- res = sign ? two's complement of magnitude : magnitude.
- Next state DONE.
REQ-010 DONE SHALL hold out_valid = 1 with res, ovf and inexact stable until out_ready; the transfer edge returns the FSM to IDLE.
REQ-011 States IDLE, SHIFT, ROUND, DONE; no other transitions.
REQ-012 Latency from input-transfer edge to out_valid rising: 1 cycle for REQ-005 classes; count + 2 cycles otherwise (max 26).
REQ-013 Magnitude never exceeds 2^31 - 1 after rounding (E <= 30), so no post-round overflow check is needed.
REQ-014 -0.0 SHALL yield res = 0 with ovf = 0 and inexact = 0.

Reset
REQ-015 rst SHALL immediately set state IDLE, count 0, res 0, ovf 0, inexact 0, out_valid 0; in_ready reads 1 while in IDLE.
REQ-016 rst asserted during SHIFT/ROUND/DONE SHALL discard the operation with no out_valid pulse.

Structure
REQ-017 Package fp_pkg SHALL hold BIAS = 127, EXP_W = 8, FRAC_W = 23, INT_MAX = 0x7FFFFFFF, INT_MIN = 0x80000000, and the FSM state enum, shared with the adder.
REQ-018 One sub-module fp_unpack (combinational) SHALL split fields and produce hidden bit, E and class (zero, denormal, normal, inf, nan).

Verification
REQ-019 a = 0x40490FDB (3.14159) -> res 3, inexact 1, ovf 0, out_valid 24 cycles after accept.
REQ-020 a = 0x3FC00000 (1.5) -> 2; a = 0x40200000 (2.5) -> 2; a = 0xBFC00000 -> 0xFFFFFFFE; all with inexact 1.
REQ-021 a = 0xCF000000 -> 0x80000000, ovf 0; a = 0x4F000000 -> 0x7FFFFFFF, ovf 1; a = 0x7FC00000 -> 0x7FFFFFFF, ovf 1; each 1 cycle after accept.
REQ-022 a = 0x4B000000 (2^23) -> 8388608, inexact 0, latency 2; a = 0x00000001 -> 0, inexact 1.
REQ-023 Backpressure: out_ready low for 5 cycles in DONE -> res and flags stable, in_ready 0, then a single transfer.
REQ-024 rst pulsed mid-SHIFT -> all outputs 0 immediately, no out_valid, in_ready 1, and the next operand converts correctly.
